cbus_arbiter: RTL
=================

# cbus_arbiter

Round-robin arbiter that merges NUM_INPUTS cbus masters (instruction fetch, data access, page-table walker) onto one cbus request stream. It sits directly upstream of the PMP checker: its oreq feeds the PMP ireq, and the PMP iresp returns to it as oresp. It holds each grant for the whole transaction, through the beat carrying `last`, so bursts are never interleaved.

## Interface
- NUM_INPUTS, default 2: number of masters; legal range 2..4.
- clk  input  1  clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ireqs  input  cbus_req_t[NUM_INPUTS]  requests from the masters; index 0 is instruction fetch.
- iresps  output  cbus_resp_t[NUM_INPUTS]  responses to the masters.
- oreq  output  cbus_req_t  merged request to the PMP stage.
- oresp  input  cbus_resp_t  response from the PMP stage.

## Operation
- State: `busy` (1 bit), `index` (granted master, clog2(NUM_INPUTS) bits), `ptr` (round-robin priority pointer, same width).
- IDLE (busy=0):
  - oreq = '0 and every iresps[i] = '0.
  - If any ireqs[i].valid is set, pick the first valid master scanning ptr, ptr+1, … modulo NUM_INPUTS.
  - Register the pick into `index` and set busy=1.
  - No request is forwarded in the selection cycle.
- BUSY (busy=1):
  - oreq = ireqs[index], passed through combinationally.
  - iresps[index] = oresp.
  - iresps[j] = '0 for every j ≠ index.
- Completion: in BUSY, when oresp.ready && oresp.last, go to IDLE next cycle and set ptr = (index+1) mod NUM_INPUTS.
  - Wrap-around example: with NUM_INPUTS=3, index=2 gives ptr=0.
  - ptr changes only on completion or abort.
- Abort: in BUSY, when ireqs[index].valid = 0, go to IDLE next cycle and advance ptr the same way.
  - oreq.valid is 0 in that cycle because of the pass-through.
  - Masters must not abort a transaction. This rule exists only so the arbiter cannot deadlock.
- Simultaneous events:
  - Completion or abort and a new valid request in the same cycle: the new request is not examined that cycle. Selection happens in the following IDLE cycle, using the updated ptr.
  - Several valid masters in IDLE: exactly one is granted, according to ptr.
- Requests from masters that are not granted are neither modified nor acknowledged. Those masters keep valid asserted and wait.
- The arbiter does not interpret addr, size, strobe, len or burst. PMP-generated error responses (ready=1, last=1, data=0) end a transaction exactly like memory responses.

## Timing
- Reset values: busy=0, index=0, ptr=0. Therefore oreq='0 and all iresps='0 from the first cycle after reset.
- Reset mid-transaction returns to IDLE immediately. The outstanding transaction is dropped and no response is forwarded.
- Grant latency: a request that becomes valid in an IDLE cycle appears on oreq in the next cycle. This is one bubble cycle.
- Response path: oresp → iresps[index] is combinational, zero cycles.
- Request path: ireqs[index] → oreq is combinational, zero cycles.
- Back-to-back transactions: a completion at cycle t gives IDLE at t+1, with selection at t+1 if any request is valid, and the next grant on oreq at t+2. Minimum spacing is therefore 2 cycles between `last` beats of consecutive transactions.
- No combinational path from oresp to busy, index or ptr. These update only on the clock edge.

## Test plan
- Single master:
  - Stimulus: after reset, ireqs[1] reads addr 0x8000_0000, len 0, and the memory model returns ready/last with data 0xdead_beef two cycles after the grant.
  - Required: oreq.addr = 0x8000_0000 one cycle after valid; iresps[1].data = 0xdead_beef; iresps[0] stays '0.
- Contention and fairness:
  - Stimulus: masters 0 and 1 both hold valid continuously.
  - Required: grants alternate 0, 1, 0, 1 with ptr=0 at the start; neither master is granted twice in a row.
- Burst lock:
  - Stimulus: master 0 issues a len=3 burst (4 beats) while master 1 becomes valid at beat 2.
  - Required: oreq stays master 0 for all 4 beats; master 1 is granted 2 cycles after master 0's `last` beat.
- PMP error response:
  - Stimulus: oresp returns ready=1, last=1, data=0 on the first BUSY cycle.
  - Required: transaction ends; iresps[index] sees exactly one ready beat; ptr advances.
- Wrap-around with NUM_INPUTS=3:
  - Stimulus: master 2 completes, then masters 0 and 2 are both valid.
  - Required: master 0 is granted.
- Reset and abort:
  - Stimulus: assert reset in the middle of a 4-beat burst; separately, drop the granted master's valid in BUSY.
  - Required:
    - Reset: next cycle busy=0, ptr=0, oreq='0.
    - Abort: IDLE next cycle and ptr = index+1.

Source files
------------

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter merging NUM_INPUTS cbus masters onto one request stream, grant held through last beat
// Ports: clk, reset (sync, active-high); ireqs/iresps master side; oreq/oresp toward the PMP checker.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strobe;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_INPUTS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);
    localparam int IW = $clog2(NUM_INPUTS);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        r_state, w_state;
    logic [IW-1:0] r_index, w_index, r_ptr, w_ptr, w_next;
    logic          w_found;
    assign w_next = (r_index == IW'(NUM_INPUTS - 1)) ? '0 : r_index + IW'(1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_index <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state;
            r_index <= w_index;
            r_ptr   <= w_ptr;
        end
    end
    always_comb begin
        w_state = r_state;
        w_index = r_index;
        w_ptr   = r_ptr;
        w_found = 1'b0;
        oreq    = '0;
        for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
        if (r_state == IDLE) begin
            // first valid master at or after ptr, wrapping
            for (int k = 0; k < NUM_INPUTS; k++) begin
                if (!w_found && ireqs[(int'(r_ptr) + k) % NUM_INPUTS].valid) begin
                    w_found = 1'b1;
                    w_index = IW'((int'(r_ptr) + k) % NUM_INPUTS);
                end
            end
            w_state = w_found ? BUSY : IDLE;
        end else begin
            oreq            = ireqs[r_index];
            iresps[r_index] = oresp;
            // a dropped valid releases the bus so a misbehaving master cannot deadlock it
            if (!ireqs[r_index].valid || (oresp.ready && oresp.last)) begin
                w_state = IDLE;
                w_ptr   = w_next;
            end
        end
    end
endmodule
